pixel_lane_add_stream: RTL and testbench
========================================

// Module: pixel_lane_add_stream
// PURPOSE
//  Parametrised successor to the 64-bit pixel app wrapper. Accepts 64-bit words on a
//  valid/ready stream and splits each word into groups of LANES pixels. Each pixel is
//  incremented by ADDEND in a STAGES-deep stallable pipeline. The groups are then
//  repacked into 64-bit output words. Sits between host DMA and downstream pixel sinks.
// PARAMETERS
//  BITS     4  log2 pixel width; 3..5 (PIXELWIDTH=1<<BITS = 8/16/32)
//  LANES    2  pixels per group, power of 2; LANES*PIXELWIDTH <= 64
//  STAGES   2  pipeline register stages in the adder path, 1..4
//  ADDEND   1  per-pixel constant added, PIXELWIDTH bits
// PORTS
//  clk         in   1   sole clock, rising edge
//  rst         in   1   synchronous, active-high reset
//  din         in   64  input word, pixel 0 in bits [PIXELWIDTH-1:0]
//  din_valid   in   1   input word valid
//  din_ready   out  1   input word accepted when din_valid&&din_ready
//  dout        out  64  output word, same pixel ordering as din
//  dout_valid  out  1   output word valid
//  dout_ready  in   1   downstream accept
//  words_out   out  32  count of completed dout handshakes since reset, wraps at 2^32
// BEHAVIOUR
//  - Derived values: GW = LANES*PIXELWIDTH and BEATS = 64/GW. Group k = word[k*GW +: GW], sent lowest k first.
//  - Reset (rst=1 at an edge): all pipeline valids, dout_valid and words_out go to 0, and dout
//    goes to 0. The partial word in the serializer or deserializer is discarded. din_ready is 0 while rst=1.
//  - Serializer: holds one word and a beat index 0..BEATS-1.
//    din_ready = !ser_full || (ser_beat==BEATS-1 && adv). A new word can load in the same cycle
//    the last beat leaves, with no bubble.
//  - Pipeline: one global enable, adv = !last_valid || deser_can_take. All stages shift together
//    when adv=1 and hold otherwise. Bubbles are not squeezed out.
//  - Deserializer: writes beat k into bits k*GW. After BEATS beats it asserts dout_valid.
//    deser_can_take = !dout_valid || dout_ready. This allows the first beat of the next word in
//    the same cycle as the dout handshake.
//  - dout and dout_valid are registered. While dout_valid=1 && dout_ready=0, dout holds stable.
//  - Latency: a din handshake at edge t gives dout_valid at edge t+BEATS+STAGES, with no backpressure.
//  - Throughput: one group per cycle, so one word per BEATS cycles (BEATS=1: one word per cycle).
//  - Arithmetic: each lane is pix + ADDEND mod 2^PIXELWIDTH. Lanes are independent; there is no
//    carry between lanes.
//  - words_out increments on each dout_valid&&dout_ready. It rolls 0xFFFFFFFF to 0.
//  - Parameter violations (LANES*PIXELWIDTH>64, or STAGES outside 1..4) are flagged by an
//    elaboration-time $error.
// CONFIGURATION
//  ADD_SAT_EN defined: each lane saturates at 2^PIXELWIDTH-1 instead of wrapping.
//  ADD_SAT_EN undefined: modulo wrap.
//  Handshake timing and latency are identical in both builds.
// STRUCTURE
//  Package pixel_stream_pkg provides:
//   - functions for PIXELWIDTH, GW and BEATS from BITS and LANES;
//   - function lane_add(pix, addend), with the saturating variant selected under ADD_SAT_EN.
//  Sub-module pixel_lane_add_stage is one registered stage: LANES adders plus a valid bit and
//  an enable input. It is instantiated STAGES times. Only stage 1 computes; later stages pass
//  data through. Serializer and deserializer are inline.
// TESTING
//  1 BITS=4,LANES=2: din=0x0004_0003_0002_0001, dout_ready=1 -> dout=0x0005_0004_0003_0002,
//    dout_valid 4 cycles after accept.
//  2 Wrap: din=0xFFFF_FFFF_FFFF_FFFF -> dout=0x0000_0000_0000_0000.
//    With ADD_SAT_EN -> 0xFFFF_FFFF_FFFF_FFFF.
//  3 Backpressure: 4 words back-to-back, dout_ready=0 for 10 cycles -> dout stable,
//    din_ready drops once the pipe is full. Release -> 4 words in order, words_out=4.
//  4 BITS=3,LANES=8, din streaming 0x0706050403020100 every cycle, dout_ready=1 ->
//    0x0807060504030201 every cycle, no bubbles.
//  5 Reset mid-word: assert rst after beat 0 of a word -> no dout_valid, words_out=0.
//    The next word 0x1 gives 0x0001_0001_0001_0002.
//  6 Random valid/ready toggling on 1000 words vs scoreboard -> exact match and in-order delivery.

Source files
------------

// File: rtl/pixel_stream_pkg.sv
// Shared sizing helpers and per-lane arithmetic for the pixel lane add stream.
// Build option: define ADD_SAT_EN for saturating lanes (default: modulo wrap).
package pixel_stream_pkg;

   localparam int WORD_W = 64;

   function automatic int pixel_width(input int bits);
      return 1 << bits;
   endfunction

   function automatic int group_width(input int bits, input int lanes);
      return lanes * pixel_width(bits);
   endfunction

   // Clamped to 1 so an illegal configuration still elaborates far enough to report itself.
   function automatic int beat_count(input int bits, input int lanes);
      int gw;
      gw = group_width(bits, lanes);
      if (gw <= 0 || gw > WORD_W) return 1;
      return WORD_W / gw;
   endfunction

   function automatic logic [31:0] lane_add(input logic [31:0] pix, input logic [31:0] addend,
                                            input int pw);
      logic [32:0] mask;
      logic [32:0] sum;
      mask = (33'd1 << pw) - 33'd1;
      sum  = ({1'b0, pix} & mask) + ({1'b0, addend} & mask);
`ifdef ADD_SAT_EN
      if (sum > mask) sum = mask;
`else
      sum = sum & mask;
`endif
      return sum[31:0];
   endfunction

endpackage

// File: rtl/pixel_lane_add_stage.sv
// One stallable pipeline register for a group of LANES pixels. With COMPUTE set the
// stage adds ADDEND to every lane; otherwise it forwards its input unchanged.
module pixel_lane_add_stage
   import pixel_stream_pkg::*;
#(
   parameter int          PW      = 16,
   parameter int          LANES   = 2,
   parameter bit          COMPUTE = 1'b1,
   parameter int unsigned ADDEND  = 1
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic                  in_valid,
   input  logic [LANES*PW-1:0]   in_data,
   output logic                  out_valid,
   output logic [LANES*PW-1:0]   out_data
);

   logic [LANES*PW-1:0] result;

   always_comb begin
      result = in_data;
      if (COMPUTE) begin
         for (int i = 0; i < LANES; i++) begin
            result[i*PW +: PW] = PW'(lane_add(32'(in_data[i*PW +: PW]), ADDEND, PW));
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= '0;
      end else if (en) begin
         out_valid <= in_valid;
         out_data  <= result;
      end
   end

endmodule

// File: rtl/pixel_lane_add_stream.sv
// 64-bit valid/ready stream: split into LANES-pixel groups, add ADDEND per pixel in a
// STAGES-deep stallable pipe, repack into 64-bit words. ADD_SAT_EN selects saturation.
module pixel_lane_add_stream
   import pixel_stream_pkg::*;
#(
   parameter int          BITS   = 4,
   parameter int          LANES  = 2,
   parameter int          STAGES = 2,
   parameter int unsigned ADDEND = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [63:0] din,
   input  logic        din_valid,
   output logic        din_ready,
   output logic [63:0] dout,
   output logic        dout_valid,
   input  logic        dout_ready,
   output logic [31:0] words_out
);

   localparam int PW    = pixel_width(BITS);
   localparam int GW    = group_width(BITS, LANES);
   localparam int BEATS = beat_count(BITS, LANES);
   localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;

   generate
      if (GW > WORD_W) begin : g_bad_width
         $error("pixel_lane_add_stream: LANES*PIXELWIDTH (%0d) exceeds 64", GW);
      end
      if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
         $error("pixel_lane_add_stream: STAGES (%0d) must be 1..4", STAGES);
      end
      if (BITS < 3 || BITS > 5) begin : g_bad_bits
         $error("pixel_lane_add_stream: BITS (%0d) must be 3..5", BITS);
      end
      if (LANES < 1 || (LANES & (LANES - 1)) != 0) begin : g_bad_lanes
         $error("pixel_lane_add_stream: LANES (%0d) must be a power of 2", LANES);
      end
   endgenerate

   logic          adv;
   logic          last_valid;
   logic          deser_can_take;
   logic          din_fire;
   logic          dout_fire;

   // ---------------- serializer ----------------
   logic [63:0]   ser_word;
   logic [BW-1:0] ser_beat;
   logic          ser_full;
   logic          ser_last;
   logic [GW-1:0] ser_grp;

   assign ser_last  = (ser_beat == BW'(BEATS - 1));
   // A fresh word may load on the same edge the final beat of the current one leaves.
   assign din_ready = !rst && (!ser_full || (ser_last && adv));
   assign din_fire  = din_valid && din_ready;

   always_comb begin
      ser_grp = '0;
      for (int k = 0; k < BEATS; k++) begin
         if (ser_beat == BW'(k)) ser_grp = ser_word[k*GW +: GW];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ser_word <= '0;
         ser_beat <= '0;
         ser_full <= 1'b0;
      end else if (din_fire) begin
         ser_word <= din;
         ser_beat <= '0;
         ser_full <= 1'b1;
      end else if (adv && ser_full) begin
         if (ser_last) ser_full <= 1'b0;
         else          ser_beat <= ser_beat + 1'b1;
      end
   end

   // ---------------- adder pipeline ----------------
   logic [STAGES:0] pv;
   logic [GW-1:0]   pd [0:STAGES];

   assign pv[0] = ser_full;
   assign pd[0] = ser_grp;

   generate
      for (genvar s = 0; s < STAGES; s++) begin : g_stage
         pixel_lane_add_stage #(
            .PW      (PW),
            .LANES   (LANES),
            .COMPUTE (s == 0),
            .ADDEND  (ADDEND)
         ) u_stage (
            .clk       (clk),
            .rst       (rst),
            .en        (adv),
            .in_valid  (pv[s]),
            .in_data   (pd[s]),
            .out_valid (pv[s+1]),
            .out_data  (pd[s+1])
         );
      end
   endgenerate

   assign last_valid = pv[STAGES];

   // ---------------- deserializer ----------------
   logic [63:0]   deser_buf;
   logic [63:0]   deser_next;
   logic [BW-1:0] deser_beat;
   logic          deser_last;

   // Taking a beat is allowed in the same cycle the held output word is accepted.
   assign deser_can_take = !dout_valid || dout_ready;
   assign adv            = !last_valid || deser_can_take;
   assign dout_fire      = dout_valid && dout_ready;
   assign deser_last     = (deser_beat == BW'(BEATS - 1));

   always_comb begin
      deser_next = deser_buf;
      for (int k = 0; k < BEATS; k++) begin
         if (deser_beat == BW'(k)) deser_next[k*GW +: GW] = pd[STAGES];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         deser_buf  <= '0;
         deser_beat <= '0;
         dout       <= '0;
         dout_valid <= 1'b0;
         words_out  <= '0;
      end else begin
         if (dout_fire) begin
            dout_valid <= 1'b0;
            words_out  <= words_out + 32'd1;
         end
         if (last_valid && adv) begin
            if (deser_last) begin
               dout       <= deser_next;
               dout_valid <= 1'b1;
               deser_beat <= '0;
               deser_buf  <= '0;
            end else begin
               deser_buf  <= deser_next;
               deser_beat <= deser_beat + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pixel_lane_add_stream.sv
// Directed bench for pixel_lane_add_stream: default 16-bit/2-lane instance plus an
// 8-bit/8-lane instance for the one-word-per-cycle case. Honours ADD_SAT_EN.
module tb_pixel_lane_add_stream;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic [63:0] din = '0;
   logic        din_valid = 1'b0;
   logic        din_ready;
   logic [63:0] dout;
   logic        dout_valid;
   logic        dout_ready = 1'b1;
   logic [31:0] words_out;

   logic [63:0] b_din = '0;
   logic        b_din_valid = 1'b0;
   logic        b_din_ready;
   logic [63:0] b_dout;
   logic        b_dout_valid;
   logic        b_dout_ready = 1'b1;
   logic [31:0] b_words_out;

   int          total = 0;
   int          bad = 0;
   logic [63:0] exp_q[$];
   logic [63:0] mon_exp;
   bit          sends_done;
   bit          rdy_stop;

   always #5 clk = ~clk;

   pixel_lane_add_stream #(.BITS(4), .LANES(2), .STAGES(2), .ADDEND(1)) u_dut (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
      .dout(dout), .dout_valid(dout_valid), .dout_ready(dout_ready), .words_out(words_out)
   );

   pixel_lane_add_stream #(.BITS(3), .LANES(8), .STAGES(2), .ADDEND(1)) u_dut8 (
      .clk(clk), .rst(rst), .din(b_din), .din_valid(b_din_valid), .din_ready(b_din_ready),
      .dout(b_dout), .dout_valid(b_dout_valid), .dout_ready(b_dout_ready), .words_out(b_words_out)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [63:0] model(input logic [63:0] w);
      logic [16:0] s;
      model = '0;
      for (int i = 0; i < 4; i++) begin
         s = {1'b0, w[i*16 +: 16]} + 17'd1;
`ifdef ADD_SAT_EN
         if (s[16]) s = 17'h0FFFF;
`endif
         model[i*16 +: 16] = s[15:0];
      end
   endfunction

   task automatic sync();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sync();
      rst = 1'b1;
      din_valid = 1'b0;
      b_din_valid = 1'b0;
      repeat (2) sync();
      rst = 1'b0;
   endtask

   // Called at posedge+1; returns at posedge+1 just after the handshake edge.
   task automatic send_a(input logic [63:0] w, input logic [63:0] e);
      int n;
      n = 0;
      din = w;
      din_valid = 1'b1;
      @(negedge clk);
      while (!din_ready && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("din_accept", {63'd0, din_ready}, 64'd1);
      exp_q.push_back(e);
      sync();
      din_valid = 1'b0;
   endtask

   task automatic drain(input string tag);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 3000) begin
         @(negedge clk);
         n++;
      end
      check(tag, 64'(exp_q.size()), 64'd0);
      repeat (3) sync();
   endtask

   // Every accepted output word must be the next expected one.
   always @(negedge clk) begin
      if (!rst && dout_valid && dout_ready) begin
         if (exp_q.size() == 0) begin
            check("dout_extra", 64'd0, 64'd1);
         end else begin
            mon_exp = exp_q.pop_front();
            check("dout_data", dout, mon_exp);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int          lat;
      logic [63:0] held;
      logic [31:0] w0;
      logic [63:0] w;

      // ---- reset state ----
      do_reset();
      rst = 1'b1;
      @(negedge clk);
      check("rst_din_ready", {63'd0, din_ready}, 64'd0);
      check("rst_dout_valid", {63'd0, dout_valid}, 64'd0);
      check("rst_dout", dout, 64'd0);
      check("rst_words_out", 64'(words_out), 64'd0);
      check("rst_b_din_ready", {63'd0, b_din_ready}, 64'd0);
      sync();
      rst = 1'b0;
      @(negedge clk);
      check("idle_din_ready", {63'd0, din_ready}, 64'd1);
      sync();

      // ---- 8-lane 8-bit streaming, one word per cycle ----
      b_din = 64'h0706050403020100;
      b_din_valid = 1'b1;
      b_dout_ready = 1'b1;
      repeat (4) sync();
      @(negedge clk);
      w0 = b_words_out;
      for (int i = 0; i < 16; i++) begin
         @(negedge clk);
         check("b_dout_valid", {63'd0, b_dout_valid}, 64'd1);
         check("b_dout", b_dout, 64'h0807060504030201);
         check("b_din_ready", {63'd0, b_din_ready}, 64'd1);
      end
      check("b_words_out", 64'(b_words_out), 64'(w0 + 32'd16));
      sync();
      b_din_valid = 1'b0;

      // ---- basic word and latency ----
      dout_ready = 1'b1;
      send_a(64'h0004_0003_0002_0001, 64'h0005_0004_0003_0002);
      lat = 0;
      @(negedge clk);
      while (!dout_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      check("latency", 64'(lat), 64'd4);
      sync();
      drain("drain_basic");

      // ---- lane wrap / saturate ----
`ifdef ADD_SAT_EN
      send_a(64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF);
`else
      send_a(64'hFFFF_FFFF_FFFF_FFFF, 64'h0000_0000_0000_0000);
`endif
      drain("drain_wrap");
      check("words_out_2", 64'(words_out), 64'd2);

      // ---- backpressure ----
      do_reset();
      dout_ready = 1'b0;
      sends_done = 1'b0;
      fork
         begin
            send_a(64'h0001_0002_0003_0004, 64'h0002_0003_0004_0005);
            send_a(64'h1111_2222_3333_4444, 64'h1112_2223_3334_4445);
            send_a(64'h00FF_0100_7FFF_8000, 64'h0100_0101_8000_8001);
            send_a(64'hABCD_0000_1234_FFFE, 64'hABCE_0001_1235_FFFF);
            sends_done = 1'b1;
         end
      join_none
      lat = 0;
      @(negedge clk);
      while (!dout_valid && lat < 20) begin
         @(negedge clk);
         lat++;
      end
      held = dout;
      check("bp_first_word", held, 64'h0002_0003_0004_0005);
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         check("bp_dout_stable", dout, held);
         check("bp_dout_valid", {63'd0, dout_valid}, 64'd1);
      end
      check("bp_din_ready_low", {63'd0, din_ready}, 64'd0);
      sync();
      dout_ready = 1'b1;
      lat = 0;
      while (!sends_done && lat < 200) begin
         sync();
         lat++;
      end
      check("bp_sends_done", {63'd0, sends_done}, 64'd1);
      drain("drain_bp");
      check("bp_words_out", 64'(words_out), 64'd4);

      // ---- reset in the middle of a word ----
      send_a(64'hDEAD_BEEF_0123_4567, 64'hDEAE_BEF0_0124_4568);
      exp_q.delete();
      do_reset();
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("mid_rst_no_valid", {63'd0, dout_valid}, 64'd0);
      end
      check("mid_rst_words_out", 64'(words_out), 64'd0);
      sync();
      send_a(64'h0000_0000_0000_0001, 64'h0001_0001_0001_0002);
      drain("drain_after_rst");
      check("after_rst_words_out", 64'(words_out), 64'd1);

      // ---- random valid/ready traffic ----
      rdy_stop = 1'b0;
      fork
         begin
            while (!rdy_stop) begin
               sync();
               dout_ready = 1'($urandom_range(0, 1));
            end
         end
      join_none
      for (int i = 0; i < 1000; i++) begin
         w = {$urandom, $urandom};
         if (i % 50 == 0) w = 64'hFFFF_0000_FFFF_0000;
         send_a(w, model(w));
         repeat ($urandom_range(0, 2)) sync();
      end
      rdy_stop = 1'b1;
      repeat (2) sync();
      dout_ready = 1'b1;
      drain("drain_random");
      @(negedge clk);
      check("random_words_out", 64'(words_out), 64'd1001);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
